// File: rtl/load_store_unit.sv
// RV32I load/store unit: decodes a core request, runs one data-memory
// transaction with timeout, and reports completion, errors and load data.
module load_store_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        is_load_i,
  input  logic        is_store_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] store_data_i,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic [3:0]  mem_be_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i,
  output logic [31:0] load_result_o,
  output logic        done_o,
  output logic        busy_o,
  output logic        misaligned_o,
  output logic        illegal_o,
  output logic        bus_err_o
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t             state, state_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [2:0]         f3, f3_n;
  logic [1:0]         off, off_n;
  logic               is_load, is_load_n;

  logic               req_n, we_n, done_n, busy_n, mis_n, ill_n, berr_n;
  logic [31:0]        addr_n, wdata_n, result_n;
  logic [3:0]         be_n;

  logic               illegal_c, misaligned_c;
  logic [3:0]         be_c;
  logic [31:0]        wdata_c;
  logic [7:0]         byte_c;
  logic [15:0]        half_c;
  logic [31:0]        load_c;

  // Request decode: legality, alignment, byte enables and lane replication
  always_comb begin
    illegal_c    = 1'b0;
    misaligned_c = 1'b0;
    be_c         = 4'b1111;
    wdata_c      = store_data_i;
    if (is_load_i && is_store_i)
      illegal_c = 1'b1;
    else if (is_load_i)
      illegal_c = (funct3_i == 3'b011) || (funct3_i[2:1] == 2'b11);
    else if (is_store_i)
      illegal_c = funct3_i[2] || (funct3_i[1:0] == 2'b11);
    case (funct3_i[1:0])
      2'b01:   misaligned_c = addr_i[0];
      2'b10:   misaligned_c = |addr_i[1:0];
      default: misaligned_c = 1'b0;
    endcase
    if (is_store_i) begin
      case (funct3_i[1:0])
        2'b00: begin
          be_c    = 4'b0001 << addr_i[1:0];
          wdata_c = {4{store_data_i[7:0]}};
        end
        2'b01: begin
          be_c    = addr_i[1] ? 4'b1100 : 4'b0011;
          wdata_c = {2{store_data_i[15:0]}};
        end
        default: ;
      endcase
    end
  end

  // Load lane extraction from the registered access offset and width
  always_comb begin
    case (off)
      2'd0:    byte_c = mem_rdata_i[7:0];
      2'd1:    byte_c = mem_rdata_i[15:8];
      2'd2:    byte_c = mem_rdata_i[23:16];
      default: byte_c = mem_rdata_i[31:24];
    endcase
    half_c = off[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
    case (f3)
      3'b000:  load_c = {{24{byte_c[7]}}, byte_c};
      3'b001:  load_c = {{16{half_c[15]}}, half_c};
      3'b100:  load_c = {24'd0, byte_c};
      3'b101:  load_c = {16'd0, half_c};
      default: load_c = mem_rdata_i;
    endcase
  end

  // Next state and next registered outputs
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    f3_n      = f3;
    off_n     = off;
    is_load_n = is_load;
    we_n      = mem_we_o;
    addr_n    = mem_addr_o;
    wdata_n   = mem_wdata_o;
    be_n      = mem_be_o;
    result_n  = load_result_o;
    mis_n     = 1'b0;
    ill_n     = 1'b0;
    berr_n    = 1'b0;
    case (state)
      IDLE: begin
        if (start_i) begin
          if (!is_load_i && !is_store_i) begin
            state_n = DONE;
          end else if (illegal_c) begin
            state_n = DONE;
            ill_n   = 1'b1;
          end else if (misaligned_c) begin
            state_n = DONE;
            mis_n   = 1'b1;
          end else begin
            state_n   = REQ;
            cnt_n     = '0;
            f3_n      = funct3_i;
            off_n     = addr_i[1:0];
            is_load_n = is_load_i;
            we_n      = is_store_i;
            addr_n    = {addr_i[31:2], 2'b00};
            wdata_n   = wdata_c;
            be_n      = be_c;
          end
        end
      end
      REQ: begin
        if (mem_ack_i) begin
          state_n = DONE;
          if (is_load) result_n = load_c;
        end else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          state_n = DONE;
          berr_n  = 1'b1;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
    req_n  = (state_n == REQ);
    done_n = (state_n == DONE);
    busy_n = (state_n != IDLE);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state         <= IDLE;
      cnt           <= '0;
      f3            <= 3'd0;
      off           <= 2'd0;
      is_load       <= 1'b0;
      mem_req_o     <= 1'b0;
      mem_we_o      <= 1'b0;
      mem_addr_o    <= 32'd0;
      mem_wdata_o   <= 32'd0;
      mem_be_o      <= 4'd0;
      load_result_o <= 32'd0;
      done_o        <= 1'b0;
      busy_o        <= 1'b0;
      misaligned_o  <= 1'b0;
      illegal_o     <= 1'b0;
      bus_err_o     <= 1'b0;
    end else begin
      state         <= state_n;
      cnt           <= cnt_n;
      f3            <= f3_n;
      off           <= off_n;
      is_load       <= is_load_n;
      mem_req_o     <= req_n;
      mem_we_o      <= we_n;
      mem_addr_o    <= addr_n;
      mem_wdata_o   <= wdata_n;
      mem_be_o      <= be_n;
      load_result_o <= result_n;
      done_o        <= done_n;
      busy_o        <= busy_n;
      misaligned_o  <= mis_n;
      illegal_o     <= ill_n;
      bus_err_o     <= berr_n;
    end
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, giving the max cycles waited for mem_ack_i before a bus error.
REQ-002 SHALL have port clk_i  in  1  single clock; all state on posedge.
REQ-003 SHALL have port rst_i  in  1  reset, asynchronous, active-high.
REQ-004 SHALL have port start_i  in  1  one-cycle request from core sequencer.
REQ-005 SHALL have ports is_load_i / is_store_i  in  1 each  access type.
REQ-006 SHALL have port funct3_i  in  3  RV32I load/store funct3.
REQ-007 SHALL have ports addr_i / store_data_i  in  32 each  effective address, rs2 value.
REQ-008 SHALL have ports mem_req_o, mem_we_o  out  1 each; mem_addr_o, mem_wdata_o  out  32 each; mem_be_o  out  4  data-memory request.
REQ-009 SHALL have ports mem_ack_i  in  1; mem_rdata_i  in  32  data-memory response.
REQ-010 SHALL have ports load_result_o  out  32 (to register-file load write-back data); done_o, busy_o, misaligned_o, illegal_o, bus_err_o  out  1 each.

Function
REQ-011 SHALL implement states IDLE, REQ, DONE; busy_o=1 in REQ and DONE.
REQ-012 SHALL, in IDLE, sample start_i; start_i is ignored in REQ and DONE.
REQ-013 SHALL treat as illegal: both is_load_i and is_store_i high; load funct3 in {011,110,111}; store funct3 not in {000,001,010}.
REQ-014 SHALL treat as misaligned: halfword with addr_i[0]=1; word with addr_i[1:0]!=00.
REQ-015 SHALL, on start_i with neither type set, or with an illegal or misaligned access, go IDLE->DONE with no bus request; illegal takes priority over misaligned.
REQ-016 SHALL, on a legal aligned start_i, go IDLE->REQ and register the access; mem_req_o asserts the following cycle.
REQ-017 SHALL hold mem_req_o=1 and mem_addr_o={addr_i[31:2],2'b00}, mem_we_o, mem_be_o, mem_wdata_o stable throughout REQ.
REQ-018 SHALL set mem_be_o for SB=1<<addr[1:0], SH=0011 (addr[1]=0) or 1100, SW=1111; loads SHALL drive 1111.
REQ-019 SHALL replicate store data across lanes: SB byte x4, SH halfword x2, SW as-is.
REQ-020 SHALL, on mem_ack_i=1 in REQ, drop mem_req_o next cycle and go REQ->DONE; ack in IDLE/DONE SHALL be ignored.
REQ-021 SHALL, on a load ack, capture the lane at addr[1:0]: LB/LH sign-extend, LBU/LHU zero-extend, LW whole word.
REQ-022 SHALL update load_result_o only on a completed load; it holds otherwise, including across stores and errors.
REQ-023 SHALL count REQ cycles in a counter cleared on entering REQ; on TIMEOUT_CYCLES cycles without ack, go REQ->DONE with bus_err_o.
REQ-024 SHALL give an ack on the same cycle the count reaches TIMEOUT_CYCLES priority over timeout.
REQ-025 SHALL pulse done_o for exactly one cycle in DONE, then go DONE->IDLE.
REQ-026 SHALL assert misaligned_o, illegal_o and bus_err_o only in the DONE cycle, at most one at a time.
REQ-027 SHALL accept a new start_i in the IDLE cycle immediately after DONE; min load/store latency is start to done_o in 3 cycles with zero-wait ack.

Reset
REQ-028 SHALL, on rst_i, go immediately to IDLE, including mid-REQ, and clear the counter.
REQ-029 SHALL, on rst_i, drive all outputs to 0, including load_result_o, mem_req_o and mem_be_o.
REQ-030 SHALL NOT have a reset abort an outstanding request via any handshake; mem_req_o simply deasserts.

Verification
REQ-031 SHALL be verified: LB addr 0x103, rdata 0x80FF_0000 with ack on the 1st REQ cycle -> load_result_o=0xFFFF_FF80, done_o at start+3.
REQ-032 SHALL be verified: SH addr 0x202, data 0x1234_ABCD -> mem_be_o=1100, mem_wdata_o=0xABCD_ABCD, mem_addr_o=0x200, mem_we_o=1.
REQ-033 SHALL be verified: LW addr 0x006 -> no mem_req_o, misaligned_o=1 with done_o, load_result_o unchanged.
REQ-034 SHALL be verified: LHU with ack withheld and TIMEOUT_CYCLES=4 -> bus_err_o with done_o after 4 REQ cycles; mem_req_o stable until then.
REQ-035 SHALL be verified: rst_i asserted during REQ -> mem_req_o=0 without a clock edge; a later LBU addr 0x001, rdata 0x0000_9900 -> 0x0000_0099.
REQ-036 SHALL be verified: store funct3=011 -> illegal_o=1, no bus request; start_i pulsed during REQ -> ignored.
